seq_divider16: RTL and testbench

- Multi-cycle unsigned restoring divider for the ALU. It is the inverse operation to the CLA adder path: repeated shift-and-subtract instead of add.
- Accepts a dividend/divisor pair on a start/busy/done handshake and returns quotient and remainder after WIDTH iterations.
- Used by the ALU for DIV/MOD opcodes; the control unit stalls on busy.

---
 rtl/alu_pkg.sv | 17 +
 rtl/cla_subtractor.sv | 43 ++++
 rtl/seq_divider16.sv | 134 +++++++++++++
 tb/tb_seq_divider16.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions for the sequential divider: state encoding and default constants.
package alu_pkg;

    // Operand/result width the ALU is built and verified at.
    localparam int DIV_WIDTH = 16;

    // Quotient reported when the divisor is zero.
    localparam logic [DIV_WIDTH-1:0] DIV_ZERO_QUOT = '1;

    // Divider control states, 2-bit encoding.
    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_RUN  = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

endpackage : alu_pkg

// File: rtl/cla_subtractor.sv
// N-bit subtractor A - B built as A + ~B + 1 with a carry-lookahead network.
// borrow_o is the inverted carry out: it is set when B > A.
module cla_subtractor #(
    parameter int N = 17
) (
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    output logic [N-1:0] diff_o,
    output logic         borrow_o
);

    logic [N-1:0] b_n;
    logic [N-1:0] gen;
    logic [N-1:0] prop;
    logic [N:0]   carry;

    assign b_n  = ~b_i;
    assign gen  = a_i & b_n;
    assign prop = a_i ^ b_n;

    // Flattened lookahead: each carry is an OR of generate terms gated by the
    // propagate chain above them, plus the all-propagate path from Cin=1.
    always_comb begin
        logic term;
        logic chain;
        // NOTE: every variable written here gets a value on every pass, so no latch is inferred.
        carry    = '0;
        carry[0] = 1'b1;
        for (int i = 0; i < N; i++) begin
            term  = 1'b0;
            chain = 1'b1;
            for (int j = i; j >= 0; j--) begin
                term  = term | (chain & gen[j]);
                chain = chain & prop[j];
            end
            carry[i+1] = term | chain;
        end
    end

    assign diff_o   = prop ^ carry[N-1:0];
    assign borrow_o = ~carry[N];

endmodule : cla_subtractor

// File: rtl/seq_divider16.sv
// Multi-cycle unsigned restoring divider: one shift-and-subtract step per clock,
// quotient and remainder after WIDTH iterations, start/busy/done handshake.
module seq_divider16
    import alu_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    div_state_e       state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] r_q,     r_d;      // partial remainder
    logic [WIDTH-1:0] q_q,     q_d;      // dividend shifting out / quotient shifting in
    logic [WIDTH-1:0] dvs_q,   dvs_d;    // captured divisor
    logic [WIDTH-1:0] quot_q,  quot_d;
    logic [WIDTH-1:0] rem_q,   rem_d;
    logic             dbz_q,   dbz_d;

    logic [WIDTH:0]   trial;
    logic [WIDTH:0]   sub_diff;
    logic             sub_borrow;
    logic             diff_msb_unused;

    // Shift the next dividend bit into the partial remainder and try subtracting the divisor.
    assign trial = {r_q, q_q[WIDTH-1]};

    cla_subtractor #(
        .N(WIDTH + 1)
    ) u_sub (
        .a_i      (trial),
        .b_i      ({1'b0, dvs_q}),
        .diff_o   (sub_diff),
        .borrow_o (sub_borrow)
    );

    // When there is no borrow the top difference bit is always zero.
    assign diff_msb_unused = sub_diff[WIDTH];

    // Next-state logic: operand capture, one restoring step per RUN cycle, result load.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        r_d     = r_q;
        q_d     = q_q;
        dvs_d   = dvs_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;

        case (state_q)
            DIV_IDLE: begin
                if (start) begin
                    if (divisor == '0) begin
                        quot_d  = '1;
                        rem_d   = dividend;
                        dbz_d   = 1'b1;
                        state_d = DIV_DONE;
                    end else begin
                        dvs_d   = divisor;
                        r_d     = '0;
                        q_d     = dividend;
                        count_d = '0;
                        state_d = DIV_RUN;
                    end
                end
            end

            DIV_RUN: begin
                r_d     = sub_borrow ? trial[WIDTH-1:0] : sub_diff[WIDTH-1:0];
                q_d     = {q_q[WIDTH-2:0], ~sub_borrow};
                count_d = count_q + 1'b1;
                if (count_q == LAST_ITER) begin
                    quot_d  = q_d;
                    rem_d   = r_d;
                    dbz_d   = 1'b0;
                    state_d = DIV_DONE;
                end
            end

            DIV_DONE: begin
                state_d = DIV_IDLE;
            end

            default: begin
                state_d = DIV_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!rst_n) begin
            // NOTE: the working registers are reset too, so an aborted operation leaves nothing behind.
            state_q <= DIV_IDLE;
            count_q <= '0;
            r_q     <= '0;
            q_q     <= '0;
            dvs_q   <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            r_q     <= r_d;
            q_q     <= q_d;
            dvs_q   <= dvs_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    assign busy        = (state_q == DIV_RUN) || (state_q == DIV_DONE);
    assign done        = (state_q == DIV_DONE);
    assign quotient    = quot_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

endmodule : seq_divider16

// File: tb/tb_seq_divider16.sv
// Self-checking bench for seq_divider16: directed scenarios plus randomized operand
// pairs against an arithmetic reference model (/ and %), including exact latency.
module tb_seq_divider16;
    import alu_pkg::*;

    localparam int W        = 16;
    localparam int LAT_NORM = W + 1;
    localparam int LAT_ZERO = 1;
    localparam int MAX_WAIT = 60;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    int vectors    = 0;
    int miscompares = 0;

    seq_divider16 #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, required completion");
        $fatal(1, "watchdog");
    end

    // Reference model: plain unsigned arithmetic.
    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] q, output logic [W-1:0] r,
                                  output logic z, output int lat);
        if (b == '0) begin
            q = DIV_ZERO_QUOT; r = a; z = 1'b1; lat = LAT_ZERO;
        end else begin
            q = a / b; r = a % b; z = 1'b0; lat = LAT_NORM;
        end
    endfunction

    // Present one start pulse, scramble the operands after acceptance, and wait for done.
    // lat counts cycles from acceptance to the done cycle; busy_n counts busy cycles in that span.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          output int lat, output int busy_n,
                          output logic [W-1:0] q, output logic [W-1:0] r, output logic z);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        dividend = W'($urandom);
        divisor  = W'($urandom);
        lat      = 1;
        busy_n   = busy ? 1 : 0;
        while (!done && lat < MAX_WAIT) begin
            @(negedge clk);
            lat++;
            if (busy) busy_n++;
        end
        q = quotient;
        r = remainder;
        z = div_by_zero;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        vectors++;
        if ({busy, done, div_by_zero} !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_flags: got busy/done/dbz=%b required 000", {busy, done, div_by_zero});
        end
        vectors++;
        if ({quotient, remainder} !== '0) begin
            miscompares++;
            $display("FAIL reset_results: got q=%h r=%h required 0/0", quotient, remainder);
        end
    endtask

    task automatic check_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] q, r, eq, er;
        logic z, ez;
        int lat, elat, bn;
        model(a, b, eq, er, ez, elat);
        run_op(a, b, lat, bn, q, r, z);
        vectors++;
        if (q !== eq || r !== er || z !== ez) begin
            miscompares++;
            $display("FAIL %s %h/%h: got q=%h r=%h z=%b required q=%h r=%h z=%b",
                     name, a, b, q, r, z, eq, er, ez);
        end
        vectors++;
        if (lat !== elat || bn !== elat) begin
            miscompares++;
            $display("FAIL %s_latency %h/%h: got done at %0d busy %0d required %0d",
                     name, a, b, lat, bn, elat);
        end
    endtask

    task automatic test_basic();
        check_op("basic", 16'd100, 16'd7);
    endtask

    task automatic test_extremes();
        check_op("max_by_one", 16'hFFFF, 16'd1);
        check_op("small_by_big", 16'd3, 16'd10);
        check_op("zero_dividend", 16'd0, 16'd9);
        check_op("equal", 16'hFFFF, 16'hFFFF);
    endtask

    task automatic test_div_zero();
        check_op("div_zero", 16'd5, 16'd0);
        check_op("div_zero_max", 16'hFFFF, 16'd0);
    endtask

    // Start held high for two operations; operands change mid-RUN.
    task automatic test_start_held();
        logic [W-1:0] eq, er;
        logic ez;
        int elat, n;
        dividend = 16'd100; divisor = 16'd7; start = 1'b1;
        @(negedge clk);
        dividend = 16'd9; divisor = 16'd3;
        n = 1;
        while (!done && n < MAX_WAIT) begin @(negedge clk); n++; end
        model(16'd100, 16'd7, eq, er, ez, elat);
        vectors++;
        if (quotient !== eq || remainder !== er || n !== elat) begin
            miscompares++;
            $display("FAIL held_first: got q=%h r=%h lat=%0d required q=%h r=%h lat=%0d",
                     quotient, remainder, n, eq, er, elat);
        end
        @(negedge clk);
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL held_idle_gap: got busy=%b required 0", busy);
        end
        @(negedge clk);
        start = 1'b0;
        n = 1;
        while (!done && n < MAX_WAIT) begin @(negedge clk); n++; end
        model(16'd9, 16'd3, eq, er, ez, elat);
        vectors++;
        if (quotient !== eq || remainder !== er || div_by_zero !== ez || n !== elat) begin
            miscompares++;
            $display("FAIL held_second: got q=%h r=%h z=%b lat=%0d required q=%h r=%h z=%b lat=%0d",
                     quotient, remainder, div_by_zero, n, eq, er, ez, elat);
        end
        @(negedge clk);
    endtask

    // Reset pulse in the middle of an operation aborts it without a done pulse.
    task automatic test_reset_mid();
        int dones;
        dividend = 16'hBEEF; divisor = 16'h0013; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        vectors++;
        if ({busy, done, div_by_zero} !== 3'b000 || {quotient, remainder} !== '0) begin
            miscompares++;
            $display("FAIL reset_mid_outputs: got busy=%b done=%b z=%b q=%h r=%h required all zero",
                     busy, done, div_by_zero, quotient, remainder);
        end
        dones = 0;
        repeat (25) begin
            @(negedge clk);
            if (done || busy) dones++;
        end
        vectors++;
        if (dones !== 0) begin
            miscompares++;
            $display("FAIL reset_mid_no_done: got %0d busy/done cycles required 0", dones);
        end
        check_op("reissue", 16'hBEEF, 16'h0013);
    endtask

    // Back-to-back operations with randomized operands, a share of them divide-by-zero.
    task automatic test_random();
        logic [W-1:0] a, b;
        for (int i = 0; i < 2000; i++) begin
            a = W'($urandom);
            case ($urandom_range(0, 7))
                0:       b = '0;
                1:       b = W'($urandom_range(1, 15));
                2:       a = W'($urandom_range(0, 255));
                default: b = W'($urandom);
            endcase
            if (i % 8 == 2) b = W'($urandom);
            check_op("random", a, b);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_extremes();
        test_div_zero();
        test_start_held();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_seq_divider16
